// File: rtl/brg_pkg.sv
// brg_pkg: shared state type, default constants and width helper for brg_prog
package brg_pkg;
  typedef enum logic {IDLE, RUN} brg_state_e;
  localparam int DIV_W_DEF = 16;
  localparam int OSR_DEF = 16;
  localparam int DIV_RST_DEF = 27;
  localparam int FRAC_W_DEF = 8;
  function automatic int osr_w(input int osr);
    return (osr < 2) ? 1 : $clog2(osr);
  endfunction
endpackage

// File: rtl/brg_mod_cnt.sv
// brg_mod_cnt: modulo-N sysclk counter with terminal-count pulse and one-cycle fractional stretch
// Ports: sysclk, rst (sync active-low), clr (restart at 0), en (count), stretch (period N+1),
//   div (modulus N), tc (combinational terminal count, high on the last cycle of the period)
module brg_mod_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             stretch,
  input  logic [DIV_W-1:0] div,
  output logic             tc
);
  logic [DIV_W-1:0] cnt;
  // terminal value is N-1, or N when this period is stretched by a fractional carry
  assign tc = cnt == div - DIV_W'(!stretch);
  always_ff @(posedge sysclk) begin
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + DIV_W'(1);
  end
endmodule

// File: rtl/brg_prog.sv
// brg_prog: programmable baud rate generator emitting oversample, mid-bit and baud clock-enable ticks
// Ports: sysclk; rst (sync active-low); en; div_val/div_load (shadowed divisor, applied at baud
//   boundaries, on resync, or at once while idle); resync (phase restart); os_tick, mid_tick,
//   baud_tick (one-cycle ticks); baud_clk (50% baud square wave); os_cnt; div_pending; cfg_err.
// Build option BRG_FRAC_EN: adds FRAC_W and frac_val, a fractional accumulator whose carry
//   stretches the following oversample period by one sysclk.
module brg_prog import brg_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF,
  parameter int OSR = OSR_DEF,
  parameter int DIV_RST = DIV_RST_DEF
`ifdef BRG_FRAC_EN
  , parameter int FRAC_W = FRAC_W_DEF
`endif
) (
  input  logic                   sysclk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [DIV_W-1:0]       div_val,
  input  logic                   div_load,
`ifdef BRG_FRAC_EN
  input  logic [FRAC_W-1:0]      frac_val,
`endif
  input  logic                   resync,
  output logic                   os_tick,
  output logic                   mid_tick,
  output logic                   baud_tick,
  output logic                   baud_clk,
  output logic [osr_w(OSR)-1:0]  os_cnt,
  output logic                   div_pending,
  output logic                   cfg_err
);
  localparam int OSR_W = osr_w(OSR);
  brg_state_e state_q, state_d;
  logic [DIV_W-1:0] div_act, div_shd;
  logic run, tc, adv, wrap, half, apply, stretch;
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: state_d = (en && div_act != '0) ? RUN : IDLE;
      RUN: state_d = (!en || div_act == '0) ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
  end
  // counting is decided on the next state so the first edge with en high already counts
  assign run = state_d == RUN;
  assign adv = run && !resync && tc;
  assign wrap = os_cnt == OSR_W'(OSR - 1);
  assign half = os_cnt == OSR_W'(OSR / 2 - 1);
  // a load in the same cycle wins over applying, so it is never applied at the edge it arrives
  assign apply = div_pending && !div_load && (!run || resync || (adv && wrap));
  brg_mod_cnt #(.DIV_W(DIV_W)) u_div (
    .sysclk (sysclk),
    .rst    (rst),
    .clr    (!run || resync),
    .en     (run),
    .stretch(stretch),
    .div    (div_act),
    .tc     (tc)
  );
`ifdef BRG_FRAC_EN
  logic [FRAC_W-1:0] frac_act, frac_shd, acc;
  logic [FRAC_W:0] sum;
  assign sum = {1'b0, acc} + {1'b0, frac_act};
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      frac_act <= '0;
      frac_shd <= '0;
      acc <= '0;
      stretch <= 1'b0;
    end else begin
      if (div_load) frac_shd <= frac_val;
      else if (apply) frac_act <= frac_shd;
      if (!run || resync) begin
        acc <= '0;
        stretch <= 1'b0;
      end else if (tc) begin
        acc <= sum[FRAC_W-1:0];
        stretch <= sum[FRAC_W];
      end
    end
  end
`else
  assign stretch = 1'b0;
`endif
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      state_q <= IDLE;
      div_act <= DIV_W'(DIV_RST);
      div_shd <= DIV_W'(DIV_RST);
      div_pending <= 1'b0;
      cfg_err <= 1'b0;
      os_cnt <= '0;
      os_tick <= 1'b0;
      mid_tick <= 1'b0;
      baud_tick <= 1'b0;
      baud_clk <= 1'b0;
    end else begin
      state_q <= state_d;
      if (div_load) begin
        div_shd <= div_val;
        div_pending <= 1'b1;
      end else if (apply) begin
        div_act <= div_shd;
        div_pending <= 1'b0;
      end
      cfg_err <= (apply ? div_shd : div_act) == '0;
      os_tick <= adv;
      mid_tick <= adv && half;
      baud_tick <= adv && wrap;
      if (!run || resync) begin
        os_cnt <= '0;
        baud_clk <= 1'b0;
      end else if (tc) begin
        os_cnt <= wrap ? '0 : os_cnt + OSR_W'(1);
        baud_clk <= half ? 1'b1 : wrap ? 1'b0 : baud_clk;
      end
    end
  end
endmodule

// File: tb/tb_brg_prog.sv
// tb_brg_prog: self-checking bench for brg_prog; expected tick cycles are queued and matched as ticks appear
`timescale 1ns/1ps
module tb_brg_prog;
  localparam int DIV_W = 16, OSR = 8, DIV_RST = 4;
  logic sysclk = 1'b0, rst = 1'b0, en = 1'b0, div_load = 1'b0, resync = 1'b0;
  logic [DIV_W-1:0] div_val = '0;
`ifdef BRG_FRAC_EN
  logic [7:0] frac_val = '0;
`endif
  logic os_tick, mid_tick, baud_tick, baud_clk, div_pending, cfg_err;
  logic [2:0] os_cnt;
  int cyc = 0, nchk = 0, nfail = 0;
  bit mon = 1'b0;
  bit [2:0] tk;
  bit due;
  int q[3][$];
  string nm[3] = '{"os_tick", "mid_tick", "baud_tick"};

  brg_prog #(.DIV_W(DIV_W), .OSR(OSR), .DIV_RST(DIV_RST)) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .en         (en),
    .div_val    (div_val),
    .div_load   (div_load),
`ifdef BRG_FRAC_EN
    .frac_val   (frac_val),
`endif
    .resync     (resync),
    .os_tick    (os_tick),
    .mid_tick   (mid_tick),
    .baud_tick  (baud_tick),
    .baud_clk   (baud_clk),
    .os_cnt     (os_cnt),
    .div_pending(div_pending),
    .cfg_err    (cfg_err)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic load(input int v);
    div_val = DIV_W'(v);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  task automatic push_run(input int t0, input int n, input int te);
    for (int t = t0 + n - 1; t < te; t += n) q[0].push_back(t);
    for (int t = t0 + OSR / 2 * n - 1; t < te; t += OSR * n) q[1].push_back(t);
    for (int t = t0 + OSR * n - 1; t < te; t += OSR * n) q[2].push_back(t);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en = 1'b1;
    repeat (3) step();
    nchk++;
    if ({os_tick, mid_tick, baud_tick, baud_clk, os_cnt, div_pending, cfg_err} !== 9'd0) begin
      nfail++;
      $display("FAIL reset_outputs: got %b want 0", {os_tick, mid_tick, baud_tick, baud_clk, os_cnt, div_pending, cfg_err});
    end
    en = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    nchk++;
    if ({os_tick, mid_tick, baud_tick, baud_clk, os_cnt, div_pending, cfg_err} !== 9'd0) begin
      nfail++;
      $display("FAIL idle_outputs: got %b want 0", {os_tick, mid_tick, baud_tick, baud_clk, os_cnt, div_pending, cfg_err});
    end
  endtask

  task automatic test_basic();
    int t0, te, r;
    t0 = cyc + 1;
    te = t0 + 96;
    push_run(t0, 4, te);
    en = 1'b1;
    mon = 1'b1;
    while (cyc < te) begin
      step();
      r = (cyc - t0) % 32;
      nchk++;
      if (os_cnt !== 3'((cyc - t0 + 1) / 4)) begin
        nfail++;
        $display("FAIL basic_os_cnt: cycle %0d got %0d want %0d", cyc - t0, os_cnt, 3'((cyc - t0 + 1) / 4));
      end
      nchk++;
      if (baud_clk !== (r >= 15 && r <= 30)) begin
        nfail++;
        $display("FAIL basic_baud_clk: cycle %0d got %b want %b", cyc - t0, baud_clk, r >= 15 && r <= 30);
      end
    end
    mon = 1'b0;
    nchk++;
    if (q[0].size() + q[1].size() + q[2].size() != 0) begin
      nfail++;
      $display("FAIL basic_drain: %0d ticks outstanding, want 0", q[0].size() + q[1].size() + q[2].size());
    end
    foreach (q[j]) q[j].delete();
    en = 1'b0;
    step();
  endtask

  task automatic test_div_load();
    int t0, te;
    bit exp_p;
    t0 = cyc + 1;
    te = t0 + 100;
    for (int t = t0 + 3; t <= t0 + 31; t += 4) q[0].push_back(t);
    for (int t = t0 + 33; t <= t0 + 63; t += 2) q[0].push_back(t);
    for (int t = t0 + 67; t < te; t += 4) q[0].push_back(t);
    q[1].push_back(t0 + 15); q[1].push_back(t0 + 39); q[1].push_back(t0 + 55); q[1].push_back(t0 + 79);
    q[2].push_back(t0 + 31); q[2].push_back(t0 + 47); q[2].push_back(t0 + 63); q[2].push_back(t0 + 95);
    en = 1'b1;
    mon = 1'b1;
    while (cyc < te) begin
      div_load = (cyc == t0 + 9) || (cyc == t0 + 46);
      div_val = (cyc < t0 + 40) ? DIV_W'(2) : DIV_W'(4);
      step();
      exp_p = (cyc >= t0 + 10 && cyc < t0 + 31) || (cyc >= t0 + 47 && cyc < t0 + 63);
      nchk++;
      if (div_pending !== exp_p) begin
        nfail++;
        $display("FAIL load_pending: cycle %0d got %b want %b", cyc - t0, div_pending, exp_p);
      end
    end
    div_load = 1'b0;
    mon = 1'b0;
    nchk++;
    if (q[0].size() + q[1].size() + q[2].size() != 0) begin
      nfail++;
      $display("FAIL load_drain: %0d ticks outstanding, want 0", q[0].size() + q[1].size() + q[2].size());
    end
    foreach (q[j]) q[j].delete();
    en = 1'b0;
    step();
  endtask

  task automatic test_n1();
    int t0, te;
    load(1);
    step();
    nchk++;
    if (div_pending !== 1'b0) begin
      nfail++;
      $display("FAIL n1_idle_apply: div_pending got %b want 0", div_pending);
    end
    t0 = cyc + 1;
    te = t0 + 40;
    push_run(t0, 1, te);
    en = 1'b1;
    mon = 1'b1;
    while (cyc < te) step();
    mon = 1'b0;
    nchk++;
    if (q[0].size() + q[1].size() + q[2].size() != 0) begin
      nfail++;
      $display("FAIL n1_drain: %0d ticks outstanding, want 0", q[0].size() + q[1].size() + q[2].size());
    end
    foreach (q[j]) q[j].delete();
    en = 1'b0;
    step();
  endtask

  task automatic test_resync();
    int t0, te;
    load(4);
    step();
    t0 = cyc + 1;
    te = t0 + 80;
    q[0].push_back(t0 + 3); q[0].push_back(t0 + 7); q[0].push_back(t0 + 11);
    for (int t = t0 + 17; t < te; t += 4) q[0].push_back(t);
    q[1].push_back(t0 + 29); q[1].push_back(t0 + 61);
    q[2].push_back(t0 + 45); q[2].push_back(t0 + 77);
    en = 1'b1;
    mon = 1'b1;
    while (cyc < te) begin
      resync = (cyc == t0 + 12);
      step();
      if (cyc == t0 + 13) begin
        nchk++;
        if (os_cnt !== 3'd0) begin
          nfail++;
          $display("FAIL resync_os_cnt: got %0d want 0", os_cnt);
        end
      end
    end
    resync = 1'b0;
    mon = 1'b0;
    nchk++;
    if (q[0].size() + q[1].size() + q[2].size() != 0) begin
      nfail++;
      $display("FAIL resync_drain: %0d ticks outstanding, want 0", q[0].size() + q[1].size() + q[2].size());
    end
    foreach (q[j]) q[j].delete();
    en = 1'b0;
    step();
  endtask

  task automatic test_zero();
    int t0, te;
    load(0);
    step();
    nchk++;
    if ({cfg_err, div_pending} !== 2'b10) begin
      nfail++;
      $display("FAIL zero_cfg_err: {cfg_err,div_pending} got %b want 10", {cfg_err, div_pending});
    end
    en = 1'b1;
    mon = 1'b1;
    repeat (100) step();
    nchk++;
    if (cfg_err !== 1'b1) begin
      nfail++;
      $display("FAIL zero_hold: cfg_err got %b want 1", cfg_err);
    end
    load(3);
    step();
    nchk++;
    if (cfg_err !== 1'b0) begin
      nfail++;
      $display("FAIL zero_clear: cfg_err got %b want 0", cfg_err);
    end
    t0 = cyc + 1;
    te = t0 + 48;
    push_run(t0, 3, te);
    while (cyc < te) step();
    mon = 1'b0;
    nchk++;
    if (q[0].size() + q[1].size() + q[2].size() != 0) begin
      nfail++;
      $display("FAIL zero_drain: %0d ticks outstanding, want 0", q[0].size() + q[1].size() + q[2].size());
    end
    foreach (q[j]) q[j].delete();
  endtask

  task automatic test_rst_mid();
    int t0, te;
    load(2);
    repeat (5) step();
    nchk++;
    if (div_pending !== 1'b1) begin
      nfail++;
      $display("FAIL rst_pre_pending: got %b want 1", div_pending);
    end
    rst = 1'b0;
    step();
    nchk++;
    if ({os_tick, mid_tick, baud_tick, baud_clk, os_cnt, div_pending, cfg_err} !== 9'd0) begin
      nfail++;
      $display("FAIL rst_mid_outputs: got %b want 0", {os_tick, mid_tick, baud_tick, baud_clk, os_cnt, div_pending, cfg_err});
    end
    rst = 1'b1;
    t0 = cyc + 1;
    te = t0 + 40;
    push_run(t0, DIV_RST, te);
    mon = 1'b1;
    while (cyc < te) step();
    mon = 1'b0;
    nchk++;
    if (q[0].size() + q[1].size() + q[2].size() != 0) begin
      nfail++;
      $display("FAIL rst_drain: %0d ticks outstanding, want 0", q[0].size() + q[1].size() + q[2].size());
    end
    foreach (q[j]) q[j].delete();
    en = 1'b0;
    step();
  endtask

`ifdef BRG_FRAC_EN
  task automatic test_frac();
    int t0, te, t;
    frac_val = 8'h80;
    load(3);
    frac_val = 8'h00;
    step();
    t0 = cyc + 1;
    te = t0 + 60;
    t = t0 + 2;
    for (int k = 1; t < te; k++) begin
      q[0].push_back(t);
      if (k % OSR == OSR / 2) q[1].push_back(t);
      if (k % OSR == 0) q[2].push_back(t);
      t += (k % 2 == 0) ? 4 : 3;
    end
    en = 1'b1;
    mon = 1'b1;
    while (cyc < te) step();
    mon = 1'b0;
    nchk++;
    if (q[0].size() + q[1].size() + q[2].size() != 0) begin
      nfail++;
      $display("FAIL frac_drain: %0d ticks outstanding, want 0", q[0].size() + q[1].size() + q[2].size());
    end
    foreach (q[j]) q[j].delete();
    en = 1'b0;
    step();
  endtask
`endif

  initial begin
    fork
      forever begin
        @(negedge sysclk);
        if (mon) begin
          tk = {baud_tick, mid_tick, os_tick};
          for (int j = 0; j < 3; j++) begin
            due = q[j].size() != 0 && q[j][0] == cyc;
            if (tk[j] || due) begin
              nchk++;
              if (tk[j] !== due) begin
                nfail++;
                $display("FAIL %s at cycle %0d: got %b want %b", nm[j], cyc, tk[j], due);
              end
              if (due) void'(q[j].pop_front());
            end
          end
        end
      end
      begin
        test_reset();
        test_basic();
        test_div_load();
        test_n1();
        test_resync();
        test_zero();
        test_rst_mid();
`ifdef BRG_FRAC_EN
        test_frac();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
      end
    join_any
  end
endmodule
